// File: rtl/rx_fcs_strip_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rx_fcs_strip_fifo
// Purpose  : Receive frame store that strips trailing FCS bytes, drops runt
//            and overflowing frames, and releases only committed frames.
// Revision : 1.0 - initial release
// ============================================================================
module rx_fcs_strip_fifo #(
    parameter int ADDR_W      = 11,
    parameter int STRIP_BYTES = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        s_axis_tvalid_i,
    input  logic [7:0]  s_axis_tdata_i,
    input  logic        s_axis_tlast_i,
    output logic        m_axis_tvalid_o,
    output logic [7:0]  m_axis_tdata_o,
    output logic        m_axis_tlast_o,
    input  logic        m_axis_tready_i,
    output logic        frame_drop_o,
    output logic [15:0] drop_count_o
);

    localparam int                  c_DEPTH   = 2 ** ADDR_W;
    localparam int                  c_DL_N    = STRIP_BYTES + 1;
    localparam int                  c_CNT_W   = $clog2(c_DL_N + 1);
    localparam logic [c_CNT_W-1:0]  c_DL_FULL = c_CNT_W'(c_DL_N);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE = c_CNT_W'(1);
    localparam logic [ADDR_W:0]     c_PTR_ONE = (ADDR_W + 1)'(1);

    logic [8:0]          r_mem [c_DEPTH];
    logic [7:0]          r_dl  [c_DL_N];
    logic [c_CNT_W-1:0]  r_dl_cnt;
    logic [ADDR_W:0]     r_wr_ptr;
    logic [ADDR_W:0]     r_commit_ptr;
    logic [ADDR_W:0]     r_rd_ptr;
    logic                r_ovf;
    logic                r_m_valid;
    logic [7:0]          r_m_data;
    logic                r_m_last;
    logic                r_drop;
    logic [15:0]         r_drop_cnt;

    logic [7:0]          w_dl_next [c_DL_N];
    logic                w_dl_full;
    logic [c_CNT_W-1:0]  w_cnt_post;
    logic                w_full_post;
    logic                w_we1;
    logic                w_we2;
    logic [ADDR_W:0]     w_ptr1;
    logic [ADDR_W:0]     w_ptr2;
    logic                w_ovf1;
    logic                w_ovf2;
    logic                w_drop;
    logic                w_commit;
    logic                w_rd_avail;
    logic                w_out_load;

    function automatic logic f_full(input logic [ADDR_W:0] wp, input logic [ADDR_W:0] rp);
        return (wp[ADDR_W] != rp[ADDR_W]) && (wp[ADDR_W-1:0] == rp[ADDR_W-1:0]);
    endfunction

    // A byte arriving with tlast can cause two stores in one cycle: the entry
    // pushed out by the shift, then the new oldest entry as the final byte.
    always_comb begin
        w_dl_next[0] = s_axis_tvalid_i ? s_axis_tdata_i : r_dl[0];
        for (int i = 1; i < c_DL_N; i++) begin
            w_dl_next[i] = s_axis_tvalid_i ? r_dl[i-1] : r_dl[i];
        end
        w_dl_full   = (r_dl_cnt == c_DL_FULL);
        w_cnt_post  = (s_axis_tvalid_i && !w_dl_full) ? r_dl_cnt + c_CNT_ONE : r_dl_cnt;
        w_full_post = (w_cnt_post == c_DL_FULL);

        w_we1  = s_axis_tvalid_i && w_dl_full && !r_ovf && !f_full(r_wr_ptr, r_rd_ptr);
        w_ovf1 = r_ovf || (s_axis_tvalid_i && w_dl_full && f_full(r_wr_ptr, r_rd_ptr));
        w_ptr1 = w_we1 ? r_wr_ptr + c_PTR_ONE : r_wr_ptr;

        w_we2  = s_axis_tlast_i && w_full_post && !w_ovf1 && !f_full(w_ptr1, r_rd_ptr);
        w_ovf2 = w_ovf1 || (s_axis_tlast_i && w_full_post && f_full(w_ptr1, r_rd_ptr));
        w_ptr2 = w_we2 ? w_ptr1 + c_PTR_ONE : w_ptr1;

        w_drop   = s_axis_tlast_i && (w_ovf2 || !w_full_post);
        w_commit = s_axis_tlast_i && !w_drop;

        w_rd_avail = (r_rd_ptr != r_commit_ptr);
        w_out_load = !r_m_valid || m_axis_tready_i;
    end

    always_ff @(posedge clk_i) begin
        if (w_we1) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= {1'b0, r_dl[STRIP_BYTES]};
        end
        if (w_we2) begin
            r_mem[w_ptr1[ADDR_W-1:0]] <= {1'b1, w_dl_next[STRIP_BYTES]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (s_axis_tvalid_i) begin
            for (int i = 0; i < c_DL_N; i++) begin
                r_dl[i] <= w_dl_next[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dl_cnt     <= '0;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_ovf        <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_last     <= 1'b0;
            r_drop       <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            if (s_axis_tlast_i) begin
                r_dl_cnt <= '0;
                r_ovf    <= 1'b0;
                if (w_commit) begin
                    r_wr_ptr     <= w_ptr2;
                    r_commit_ptr <= w_ptr2;
                end else begin
                    r_wr_ptr <= r_commit_ptr;
                end
            end else begin
                r_dl_cnt <= w_cnt_post;
                r_ovf    <= w_ovf1;
                r_wr_ptr <= w_ptr1;
            end

            r_drop <= w_drop;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end

            if (w_out_load) begin
                if (w_rd_avail) begin
                    r_m_valid <= 1'b1;
                    {r_m_last, r_m_data} <= r_mem[r_rd_ptr[ADDR_W-1:0]];
                    r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
                end else begin
                    r_m_valid <= 1'b0;
                end
            end
        end
    end

    assign m_axis_tvalid_o = r_m_valid;
    assign m_axis_tdata_o  = r_m_data;
    assign m_axis_tlast_o  = r_m_last;
    assign frame_drop_o    = r_drop;
    assign drop_count_o    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rx_fcs_strip_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_fcs_strip_fifo
// Purpose  : Directed self-checking bench for rx_fcs_strip_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_fcs_strip_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tv0, tl0, mr0, mv0, ml0, fd0;
    logic [7:0]  td0, md0;
    logic [15:0] dc0;
    logic        tv1, tl1, mr1, mv1, ml1, fd1;
    logic [7:0]  td1, md1;
    logic [15:0] dc1;

    int n_chk = 0;
    int n_err = 0;
    int stab_err = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       hold_prev = 1'b0;
    logic [8:0] hold_val  = '0;

    always #5 clk = ~clk;

    rx_fcs_strip_fifo u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .s_axis_tvalid_i(tv0), .s_axis_tdata_i(td0), .s_axis_tlast_i(tl0),
        .m_axis_tvalid_o(mv0), .m_axis_tdata_o(md0), .m_axis_tlast_o(ml0),
        .m_axis_tready_i(mr0), .frame_drop_o(fd0), .drop_count_o(dc0)
    );

    rx_fcs_strip_fifo #(.ADDR_W(6), .STRIP_BYTES(4)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .s_axis_tvalid_i(tv1), .s_axis_tdata_i(td1), .s_axis_tlast_i(tl1),
        .m_axis_tvalid_o(mv1), .m_axis_tdata_o(md1), .m_axis_tlast_o(ml1),
        .m_axis_tready_i(mr1), .frame_drop_o(fd1), .drop_count_o(dc1)
    );

    // Transfers are recorded mid-cycle, ahead of the edge that completes them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mv0 && mr0) q0.push_back({ml0, md0});
            if (mv1 && mr1) q1.push_back({ml1, md1});
            if (hold_prev && !(mv0 && ({ml0, md0} == hold_val))) stab_err++;
            hold_prev = mv0 && !mr0;
            hold_val  = {ml0, md0};
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int u, input logic [7:0] b, input logic l);
        if (u == 0) begin
            tv0 = 1'b1; td0 = b; tl0 = l;
        end else begin
            tv1 = 1'b1; td1 = b; tl1 = l;
        end
        tick();
        tv0 = 1'b0; tl0 = 1'b0;
        tv1 = 1'b0; tl1 = 1'b0;
    endtask

    function automatic int qlen(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    task automatic wait_q(input int u, input int n);
        int k = 0;
        while (qlen(u) < n && k < 2000) begin
            tick();
            k++;
        end
    endtask

    task automatic chk_frame(input string tag, input int u, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            logic [8:0] got;
            logic [8:0] exp;
            got = 'x;
            if (i < qlen(u)) got = (u == 0) ? q0[i] : q1[i];
            exp = {(i == n - 1), 8'(base + i)};
            chk(tag, {23'd0, got}, {23'd0, exp});
        end
        if (u == 0) q0.delete(); else q1.delete();
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        tv0 = 0; tl0 = 0; td0 = 0; mr0 = 1;
        tv1 = 0; tl1 = 0; td1 = 0; mr1 = 0;
        repeat (2) tick();
        chk("rst_valid", {31'd0, mv0}, 32'd0);
        chk("rst_data",  {24'd0, md0}, 32'd0);
        chk("rst_last",  {31'd0, ml0}, 32'd0);
        chk("rst_drop",  {31'd0, fd0}, 32'd0);
        chk("rst_count", {16'd0, dc0}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 64-byte frame: 60 payload bytes, 2-cycle latency, no bubbles
        for (int i = 0; i < 63; i++) send(0, 8'(i), 1'b0);
        tv0 = 1'b1; td0 = 8'h3F; tl0 = 1'b1;
        tick();
        chk("lat_cycle1", {31'd0, mv0}, 32'd0);
        tv0 = 1'b0; tl0 = 1'b0;
        tick();
        chk("lat_cycle2", {31'd0, mv0}, 32'd1);
        chk("lat_first",  {24'd0, md0}, 32'd0);
        repeat (60) tick();
        chk("no_bubble", qlen(0), 60);
        chk("drained", {31'd0, mv0}, 32'd0);
        chk_frame("f64", 0, 60, 8'h00);

        // minimal frame with standalone tlast, then a runt
        for (int i = 0; i < 5; i++) send(0, 8'hA0 + 8'(i), 1'b0);
        tl0 = 1'b1; tick(); tl0 = 1'b0;
        wait_q(0, 1);
        repeat (5) tick();
        chk("min_len", qlen(0), 1);
        chk_frame("min", 0, 1, 8'hA0);
        for (int i = 0; i < 4; i++) send(0, 8'hB0 + 8'(i), 1'b0);
        tl0 = 1'b1; tick(); tl0 = 1'b0;
        chk("runt_pulse", {31'd0, fd0}, 32'd1);
        tick();
        chk("runt_pulse_end", {31'd0, fd0}, 32'd0);
        chk("runt_count", {16'd0, dc0}, 32'd1);
        repeat (5) tick();
        chk("runt_no_out", qlen(0), 0);

        // back-pressure toggling over a 100-byte frame
        for (int i = 0; i < 100; i++) begin
            mr0 = ~mr0;
            send(0, 8'h40 + 8'(i), (i == 99));
        end
        for (int k = 0; k < 1000 && qlen(0) < 96; k++) begin
            mr0 = ~mr0;
            tick();
        end
        mr0 = 1'b1;
        repeat (5) tick();
        chk("tog_len", qlen(0), 96);
        chk("tog_stable", stab_err, 0);
        chk_frame("tog", 0, 96, 8'h40);

        // reset in the middle of a frame
        for (int i = 0; i < 20; i++) send(0, 8'h10 + 8'(i), 1'b0);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", {31'd0, mv0}, 32'd0);
        chk("mid_rst_data",  {24'd0, md0}, 32'd0);
        chk("mid_rst_last",  {31'd0, ml0}, 32'd0);
        chk("mid_rst_count", {16'd0, dc0}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) send(0, 8'hC0 + 8'(i), (i == 9));
        wait_q(0, 6);
        repeat (5) tick();
        chk("post_rst_len", qlen(0), 6);
        chk_frame("post_rst", 0, 6, 8'hC0);

        // small store: committed A held, B overflows and is dropped
        for (int i = 0; i < 40; i++) send(1, 8'(i), (i == 39));
        for (int i = 0; i < 40; i++) send(1, 8'h80 + 8'(i), (i == 39));
        chk("ovf_pulse", {31'd0, fd1}, 32'd1);
        chk("ovf_count", {16'd0, dc1}, 32'd1);
        repeat (3) tick();
        chk("ovf_hold_valid", {31'd0, mv1}, 32'd1);
        chk("ovf_hold_data",  {24'd0, md1}, 32'd0);
        mr1 = 1'b1;
        wait_q(1, 36);
        repeat (10) tick();
        chk("ovf_len", qlen(1), 36);
        chk_frame("ovf_a", 1, 36, 8'h00);

        // drop counter saturation
        tl0 = 1'b1;
        repeat (65534) tick();
        chk("sat_pre_pulse", {31'd0, fd0}, 32'd1);
        chk("sat_pre", {16'd0, dc0}, 32'h0000_FFFE);
        repeat (3) tick();
        tl0 = 1'b0;
        tick();
        chk("sat_count", {16'd0, dc0}, 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
